// File: rtl/stack_mem_arbiter.sv
// Single-port memory arbiter between the CPU control FSM (C) and the loader/debug port (L).
// Each access is issue-then-response; C has fixed priority, guarded against starving L, and L may lock the bus.
module stack_mem_arbiter #(
  parameter int unsigned AW       = 16,
  parameter int unsigned DW       = 16,
  parameter int unsigned MAX_WAIT = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          c_req,
  input  logic          c_we,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  output logic          c_ack,
  output logic          c_rvalid,
  output logic [DW-1:0] c_rdata,
  output logic          c_stall,
  input  logic          l_req,
  input  logic          l_we,
  input  logic [AW-1:0] l_addr,
  input  logic [DW-1:0] l_wdata,
  input  logic          l_lock,
  output logic          l_ack,
  output logic          l_rvalid,
  output logic [DW-1:0] l_rdata,
  output logic          m_en,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata,
  output logic          owner,
  output logic          lock_active
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  localparam logic [7:0] WAIT_MAX = 8'(MAX_WAIT);

  state_t        state_q, state_d;
  logic          win_l_q, win_l_d;
  logic          owner_q, owner_d;
  logic          lock_q, lock_d;
  logic [7:0]    wait_q, wait_d;
  logic          m_we_q, m_we_d;
  logic [AW-1:0] m_addr_q, m_addr_d;
  logic [DW-1:0] m_wdata_q, m_wdata_d;
  logic          grant, grant_l;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      win_l_q   <= 1'b0;
      owner_q   <= 1'b0;
      lock_q    <= 1'b0;
      wait_q    <= '0;
      m_we_q    <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
    end else begin
      state_q   <= state_d;
      win_l_q   <= win_l_d;
      owner_q   <= owner_d;
      lock_q    <= lock_d;
      wait_q    <= wait_d;
      m_we_q    <= m_we_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    win_l_d   = win_l_q;
    owner_d   = owner_q;
    lock_d    = lock_q;
    wait_d    = wait_q;
    m_we_d    = m_we_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    grant     = 1'b0;
    grant_l   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (lock_q) begin
          grant   = l_req;
          grant_l = 1'b1;
        end else if ((wait_q == WAIT_MAX) && l_req) begin
          grant   = 1'b1;
          grant_l = 1'b1;
        end else if (c_req) begin
          grant   = 1'b1;
          grant_l = 1'b0;
        end else if (l_req) begin
          grant   = 1'b1;
          grant_l = 1'b1;
        end

        if (!l_req)  wait_d = '0;
        if (!l_lock) lock_d = 1'b0;

        if (grant) begin
          state_d   = ISSUE;
          win_l_d   = grant_l;
          owner_d   = grant_l;
          m_we_d    = grant_l ? l_we    : c_we;
          m_addr_d  = grant_l ? l_addr  : c_addr;
          m_wdata_d = grant_l ? l_wdata : c_wdata;
          // A lock request rides on the grant, so it overrides the idle-time clear above.
          if (grant_l) begin
            wait_d = '0;
            if (l_lock) lock_d = 1'b1;
          end else if (l_req && (wait_q != WAIT_MAX)) begin
            wait_d = wait_q + 8'd1;
          end
        end
      end
      ISSUE:   state_d = m_we_q ? IDLE : RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    m_en        = (state_q == ISSUE);
    m_we        = m_en & m_we_q;
    m_addr      = m_addr_q;
    m_wdata     = m_wdata_q;
    c_ack       = m_en & ~win_l_q;
    l_ack       = m_en &  win_l_q;
    c_rvalid    = (state_q == RESP) & ~win_l_q;
    l_rvalid    = (state_q == RESP) &  win_l_q;
    c_rdata     = c_rvalid ? m_rdata : '0;
    l_rdata     = l_rvalid ? m_rdata : '0;
    c_stall     = c_req & ~c_ack;
    owner       = owner_q;
    lock_active = lock_q;
  end

endmodule

// File: doc/stack_mem_arbiter.md
Name: stack_mem_arbiter

Overview:
Shares the single-port unified memory between two requesters. Requester C is the CPU control FSM (instruction fetch and main/return stack accesses); requester L is the program loader/debug port. The block sits between both requesters and the memory macro. It sequences each access as issue then response, gives C fixed priority with a starvation guard for L, and supports an L bus lock for bulk program loads.

Parameters:
AW, 16, address width
DW, 16, data width
MAX_WAIT, 8, consecutive C grants allowed while L is pending before L is forced to win (1..255)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
c_req  in  1  C access request; held with cmd stable until c_ack
c_we  in  1  C write enable (1=write, 0=read)
c_addr  in  AW  C address
c_wdata  in  DW  C write data
c_ack  out  1  C command accepted (1-cycle pulse)
c_rvalid  out  1  C read data valid (1-cycle pulse)
c_rdata  out  DW  C read data, meaningful only when c_rvalid
c_stall  out  1  c_req & ~c_ack; CPU FSM holds state while high
l_req, l_we, l_addr, l_wdata  in  1/1/AW/DW  L command, same rules as C
l_lock  in  1  L requests exclusive ownership across accesses
l_ack, l_rvalid, l_rdata  out  1/1/DW  L handshake, same as C
m_en  out  1  memory access strobe
m_we  out  1  memory write
m_addr  out  AW  memory address
m_wdata  out  DW  memory write data
m_rdata  in  DW  memory read data, valid the cycle after a read strobe
owner  out  1  last granted requester (0=C, 1=L)
lock_active  out  1  L lock held

Behaviour:
- FSM states: IDLE, ISSUE, RESP. Arbitration is evaluated only in IDLE. The request inputs are ignored in ISSUE and RESP.
- IDLE: if any eligible request exists, latch the winner's we/addr/wdata into the m_* registers and go to ISSUE. Otherwise stay in IDLE.
- ISSUE (1 cycle): m_en=1, and m_we/m_addr/m_wdata are driven from registers. The winner's ack=1. Next state is RESP if the access is a read, IDLE if it is a write.
- RESP (1 cycle): winner's rvalid=1; winner's rdata = m_rdata (pass-through). Next state is IDLE.
- Latency, with req first seen in IDLE at cycle 0:
  - Read: ack in cycle 1, rvalid in cycle 2. Back-to-back read issue period is 3 cycles.
  - Write: ack in cycle 1. Back-to-back write issue period is 2 cycles.
- Non-winner outputs: ack, rvalid and rdata are all 0 in every cycle.
- Selection rule, first match wins:
  - lock_active=1: only L is eligible.
  - wait_cnt==MAX_WAIT and l_req: L wins.
  - c_req: C wins.
  - l_req: L wins.
- wait_cnt:
  - Increments (saturating) on each C grant while l_req=1.
  - Clears on an L grant, or in IDLE when l_req=0.
- lock_active:
  - Set on an L grant with l_lock=1.
  - Cleared in IDLE when l_lock=0.
  - C is starved for as long as the lock is held; this is by design for load mode.
- owner updates on each grant.
- c_stall is combinational.
- Requester contract: req and the command are held stable until ack. Deasserting req before ack is a protocol violation. The arbiter does not abort an already-selected access.
- Simultaneous c_req and l_req with no lock and wait_cnt<MAX_WAIT: C wins, L waits.
- Reset (rst=0), asynchronous:
  - State goes to IDLE.
  - All outputs are 0, including m_en, acks, rvalids, owner, lock_active and the data outputs.
  - wait_cnt=0.
  - An in-flight read's response is dropped. A write already strobed is not undone.
- Width rules:
  - wait_cnt is 8 bits and saturates at MAX_WAIT.
  - There is no address or data arithmetic; values pass through unchanged.

Test Plan:
1. C read, addr 0x0010, m_rdata=0xBEEF the cycle after strobe -> c_ack in cycle 1, m_en=1/m_we=0/m_addr=0x0010; c_rvalid=1 with c_rdata=0xBEEF in cycle 2; back to IDLE in cycle 3.
2. C and L both request continuously, L write to 0x0100, MAX_WAIT=8 -> C receives 8 grants, then L receives the 9th; wait_cnt clears; C wins next.
3. L write 0x0200=0x1234 with l_lock=1, then C requests while L issues 4 more writes -> c_stall stays high and no c_ack occurs; l_lock drops -> lock_active=0 in IDLE, C granted next.
4. Simultaneous single C write and L read, no lock -> C acked in cycle 1, L acked in cycle 3, l_rvalid in cycle 4, owner goes 0 then 1.
5. Assert rst=0 during RESP of an L read -> l_rvalid stays 0, all outputs 0 immediately; after release, a C read completes with normal latency.
